// File: rtl/seq_divider64.sv
// seq_divider64: iterative restoring integer divider (DIV/DIVU/REM/REMU).
// Each CALC cycle produces one quotient bit by shift-and-subtract.
// Divide-by-zero and signed overflow are resolved in IDLE without iterating.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined and
// |divisor| > |dividend|, the divider skips CALC and returns quotient 0 and
// remainder = dividend.
module seq_divider64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_zero;
  logic             is_ovf;
  logic             early_out;
  logic             skip_calc;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_iter;
  logic [WIDTH-1:0] quo_iter;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // Operand classification and magnitudes for the operation being offered.
  always_comb begin
    dvd_neg   = is_signed & dividend[WIDTH-1];
    dvs_neg   = is_signed & divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? -dividend : dividend;
    dvs_mag   = dvs_neg ? -divisor : divisor;
    is_zero   = (divisor == '0);
    is_ovf    = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
    early_out = !is_zero && (dvs_mag > dvd_mag);
`else
    early_out = 1'b0;
`endif
    skip_calc = is_zero || is_ovf || early_out;
  end

  // One restoring step. The shifted remainder can reach WIDTH+1 bits; when its
  // top bit is set it already exceeds any divisor, otherwise the trial sign decides.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_mag_q};
    trial_ok  = rem_shift[WIDTH] | ~trial[WIDTH];
    rem_iter  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_iter  = {quo_q[WIDTH-2:0], trial_ok};
    quo_final = neg_quo_q ? -quo_iter : quo_iter;
    rem_final = neg_rem_q ? -rem_iter : rem_iter;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = skip_calc ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_ONE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt       <= CNT_INIT;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_mag_q <= dvs_mag;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            if (is_zero) begin
              quotient    <= ALL_ONES;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (is_ovf) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end else if (early_out) begin
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q <= rem_iter;
          quo_q <= quo_iter;
          cnt   <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            quotient    <= quo_final;
            remainder   <= rem_final;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider64.sv
// tb_seq_divider64: randomized scoreboard bench for seq_divider64.
// A reference model based on plain integer arithmetic predicts each result and
// its latency. A monitor process pops the prediction whenever out_valid rises.
module tb_seq_divider64;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sbq[$];

  seq_divider64 dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, want 0x%h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input bit s);
    exp_t        e;
    logic [63:0] ma;
    logic [63:0] mb;
    longint      sa;
    longint      sb;
    ma = (s && a[63]) ? (64'd0 - a) : a;
    mb = (s && b[63]) ? (64'd0 - b) : b;
    e.dz = 1'b0;
    e.acc = 0;
    e.name = "";
    if (b == 64'd0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
      e.lat = 1;
    end else if (s && a == MIN_NEG && b == '1) begin
      e.q = a;
      e.r = 64'd0;
      e.lat = 1;
    end else begin
      if (s) begin
        sa = a;
        sb = b;
        e.q = 64'(sa / sb);
        e.r = 64'(sa % sb);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.lat = 65;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) e.lat = 1;
`else
      if (mb > ma) e.lat = 65;
`endif
    end
    return e;
  endfunction

  // Waits for in_ready, offers one operation for exactly one edge, and records its prediction.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input bit s,
                               input string nm, input bit track, input bit stall);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 400) begin
      if (stall) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept_timeout: got in_ready=0, want 1 within 400 cycles", nm);
      return;
    end
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    if (track) begin
      e = model(a, b, s);
      e.acc = cyc + 1;
      e.name = nm;
      sbq.push_back(e);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = 1'(($urandom_range(0, 1)));
  endtask

  // Releases backpressure until every prediction is consumed and the divider is idle.
  task automatic waitDrain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 1000) begin
      out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, want 0", sbq.size());
    end
  endtask

  // Compares each newly presented result against the oldest prediction.
  task automatic monitorLoop();
    logic prev;
    exp_t e;
    int   lat;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && !prev) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got out_valid=1, want no result pending");
        end else begin
          e = sbq.pop_front();
          lat = cyc - e.acc + 1;
          checkOutput({e.name, "_quotient"}, quotient, e.q);
          checkOutput({e.name, "_remainder"}, remainder, e.r);
          checkOutput({e.name, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
          checkOutput({e.name, "_latency"}, 64'(lat), 64'(e.lat));
        end
      end
      prev = (out_valid === 1'b1);
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    bit          s;
    int          n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;

    fork
      monitorLoop();
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_quotient", quotient, 64'd0);
    checkOutput("reset_remainder", remainder, 64'd0);
    checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(64'd100, 64'd7, 1'b0, "u100_7", 1'b1, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, "sm100_7", 1'b1, 1'b0);
    applyStimulus(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, "s100_m7", 1'b1, 1'b0);
    applyStimulus(64'h1234, 64'd0, 1'b0, "divzero", 1'b1, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 1'b1, "sdivzero", 1'b1, 1'b0);
    applyStimulus(MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "overflow", 1'b1, 1'b0);
    applyStimulus(MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "u_noovf", 1'b1, 1'b0);
    applyStimulus(64'd3, 64'd9, 1'b0, "u3_9", 1'b1, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 1'b1, "sm3_9", 1'b1, 1'b0);
    applyStimulus(MIN_NEG, 64'd1, 1'b1, "smin_1", 1'b1, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "umax_umax", 1'b1, 1'b0);
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(64'd100, 64'd7, 1'b0, "bp", 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_quotient", quotient, 64'd14);
      checkOutput("bp_hold_remainder", remainder, 64'd2);
      checkOutput("bp_hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_quotient_kept", quotient, 64'd14);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, "bp_second", 1'b1, 1'b0);
    waitDrain();

    $display("[TB] reset during CALC");
    applyStimulus(64'd1000, 64'd3, 1'b0, "abort", 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_quotient", quotient, 64'd0);
    checkOutput("abort_remainder", remainder, 64'd0);
    repeat (80) @(negedge clk);
    checkOutput("abort_no_result", 64'(out_valid), 64'd0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      s = 1'(($urandom_range(0, 1)));
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 20));
        2: b = {$urandom, $urandom};
        3: b = 64'd0 - 64'($urandom_range(1, 20));
        4: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: begin
          a = 64'($urandom_range(0, 50));
          b = 64'($urandom_range(1, 100));
        end
      endcase
      if ($urandom_range(0, 15) == 0) begin
        a = MIN_NEG;
        b = '1;
        s = 1'b1;
      end
      applyStimulus(a, b, s, "rnd", 1'b1, 1'b1);
    end
    waitDrain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
